// File: rtl/mem_access_if.sv
// SRAM-like data bus with split addr_ok/data_ok handshake between the MEM stage and the data memory.
interface mem_access_if;
  localparam int unsigned W = 32;

  logic         data_req;
  logic         data_wr;
  logic [1:0]   data_size;
  logic [W-1:0] data_addr;
  logic [W-1:0] data_wdata;
  logic         data_addr_ok;
  logic         data_data_ok;
  logic [W-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: issues loads/stores on the split-handshake data bus, formats data, selects writeback.
// Optional stall-cycle counter output enabled by defining MEM_STALL_CNT_EN.
module mem_access #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              exception_flush,
  input  logic [ADDR_W-1:0] ex_pc_i,
  input  logic [ADDR_W-1:0] ex_alu_res_i,
  input  logic [ADDR_W-1:0] ex_ls_addr_i,
  input  logic              ex_ls_ena_i,
  input  logic [3:0]        ex_ls_sel_i,
  input  logic              ex_wb_reg_sel_i,
  input  logic [ADDR_W-1:0] ex_rt_data_i,
  input  logic              ex_w_reg_ena_i,
  input  logic [4:0]        ex_w_reg_dst_i,
  input  logic              ex_has_exception_i,
  mem_access_if.master      bus,
  output logic [ADDR_W-1:0] mem_pc_o,
  output logic              mem_w_reg_ena_o,
  output logic [4:0]        mem_w_reg_dst_o,
  output logic [ADDR_W-1:0] mem_w_reg_data_o,
`ifdef MEM_STALL_CNT_EN
  output logic [31:0]       mem_stall_cnt_o,
`endif
  output logic              mem_stall_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [ADDR_W-1:0] ld_buf;
  logic [ADDR_W-1:0] ld_fmt;
  logic              access_valid;
  logic              req;
  logic              is_store;
  logic              zext;
  logic [1:0]        size;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  assign is_store     = ex_ls_sel_i[3];
  assign zext         = ex_ls_sel_i[2];
  assign size         = ex_ls_sel_i[1:0];
  assign access_valid = ex_ls_ena_i & ~ex_has_exception_i;

  // Load data alignment and extension from the byte offset.
  always_comb begin
    ld_byte = bus.data_rdata[7:0];
    ld_half = ex_ls_addr_i[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
    ld_fmt  = bus.data_rdata;
    case (ex_ls_addr_i[1:0])
      2'd1:    ld_byte = bus.data_rdata[15:8];
      2'd2:    ld_byte = bus.data_rdata[23:16];
      2'd3:    ld_byte = bus.data_rdata[31:24];
      default: ld_byte = bus.data_rdata[7:0];
    endcase
    case (size)
      2'd0:    ld_fmt = zext ? {{(ADDR_W-8){1'b0}}, ld_byte}
                             : {{(ADDR_W-8){ld_byte[7]}}, ld_byte};
      2'd1:    ld_fmt = zext ? {{(ADDR_W-16){1'b0}}, ld_half}
                             : {{(ADDR_W-16){ld_half[15]}}, ld_half};
      default: ld_fmt = bus.data_rdata;
    endcase
  end

  // Bus request fields come straight from EX/MEM, which the stall holds steady.
  always_comb begin
    bus.data_wr    = is_store;
    bus.data_size  = size;
    bus.data_addr  = ex_ls_addr_i;
    bus.data_wdata = ex_rt_data_i;
    case (size)
      2'd0:    bus.data_wdata = {4{ex_rt_data_i[7:0]}};
      2'd1:    bus.data_wdata = {2{ex_rt_data_i[15:0]}};
      default: bus.data_wdata = ex_rt_data_i;
    endcase
  end

  // Next state, request and stall.
  always_comb begin
    state_nxt   = state;
    req         = access_valid & ~exception_flush & ~rst &
                  ((state == S_IDLE) | (state == S_REQ));
    mem_stall_o = (state == S_DRAIN) |
                  (access_valid & ((state == S_IDLE) | (state == S_REQ) |
                                   ((state == S_WAIT) & ~bus.data_data_ok)));
    case (state)
      S_IDLE:  if (req) state_nxt = bus.data_addr_ok ? S_WAIT : S_REQ;
      S_REQ: begin
        if (exception_flush)       state_nxt = S_IDLE;
        else if (bus.data_addr_ok) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.data_data_ok)     state_nxt = (stall_i & ~exception_flush) ? S_DONE : S_IDLE;
        else if (exception_flush) state_nxt = S_DRAIN;
      end
      S_DONE:  if (exception_flush | ~stall_i) state_nxt = S_IDLE;
      S_DRAIN: if (bus.data_data_ok) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.data_req = req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ld_buf <= '0;
    end else begin
      state <= state_nxt;
      if ((state == S_WAIT) && bus.data_data_ok) ld_buf <= ld_fmt;
    end
  end

  // Writeback select: fresh data in the data_ok cycle, held copy while parked in DONE.
  always_comb begin
    mem_w_reg_data_o = ld_buf;
    if (!ex_wb_reg_sel_i)                           mem_w_reg_data_o = ex_alu_res_i;
    else if ((state == S_WAIT) && bus.data_data_ok) mem_w_reg_data_o = ld_fmt;
  end

  assign mem_pc_o        = ex_pc_i;
  assign mem_w_reg_ena_o = ex_w_reg_ena_i & ~ex_has_exception_i;
  assign mem_w_reg_dst_o = ex_w_reg_dst_i;

`ifdef MEM_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)              mem_stall_cnt_o <= '0;
    else if (mem_stall_o) mem_stall_cnt_o <= mem_stall_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed handshake scenarios plus randomized loads/stores vs a reference model.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        exception_flush;
  logic [31:0] ex_pc_i, ex_alu_res_i, ex_ls_addr_i, ex_rt_data_i;
  logic        ex_ls_ena_i, ex_wb_reg_sel_i, ex_w_reg_ena_i, ex_has_exception_i;
  logic [3:0]  ex_ls_sel_i;
  logic [4:0]  ex_w_reg_dst_i;
  logic [31:0] mem_pc_o, mem_w_reg_data_o;
  logic        mem_w_reg_ena_o, mem_stall_o;
  logic [4:0]  mem_w_reg_dst_o;
`ifdef MEM_STALL_CNT_EN
  logic [31:0] mem_stall_cnt_o;
  logic [31:0] exp_cnt;
`endif

  int total = 0;
  int bad   = 0;

  mem_access_if bus();

  mem_access dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .exception_flush(exception_flush),
    .ex_pc_i(ex_pc_i), .ex_alu_res_i(ex_alu_res_i), .ex_ls_addr_i(ex_ls_addr_i),
    .ex_ls_ena_i(ex_ls_ena_i), .ex_ls_sel_i(ex_ls_sel_i), .ex_wb_reg_sel_i(ex_wb_reg_sel_i),
    .ex_rt_data_i(ex_rt_data_i), .ex_w_reg_ena_i(ex_w_reg_ena_i), .ex_w_reg_dst_i(ex_w_reg_dst_i),
    .ex_has_exception_i(ex_has_exception_i), .bus(bus.master),
    .mem_pc_o(mem_pc_o), .mem_w_reg_ena_o(mem_w_reg_ena_o), .mem_w_reg_dst_o(mem_w_reg_dst_o),
    .mem_w_reg_data_o(mem_w_reg_data_o),
`ifdef MEM_STALL_CNT_EN
    .mem_stall_cnt_o(mem_stall_cnt_o),
`endif
    .mem_stall_o(mem_stall_o)
  );

  always #5 clk = ~clk;

`ifdef MEM_STALL_CNT_EN
  always @(posedge clk) begin
    if (rst) exp_cnt <= 32'd0;
    else if (mem_stall_o) exp_cnt <= exp_cnt + 32'd1;
  end
`endif

  function automatic logic [31:0] model_store(input logic [1:0] sz, input logic [31:0] rt);
    if (sz == 2'd0) return 32'(rt[7:0]) * 32'h0101_0101;
    if (sz == 2'd1) return 32'(rt[15:0]) * 32'h0001_0001;
    return rt;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic zx,
                                              input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * int'(off))) & 32'h0000_00FF;
      if (!zx && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * int'(off[1]))) & 32'h0000_FFFF;
      if (!zx && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete access with addr_ok after a wait cycles and data_ok d cycles after that; no global stall.
  task automatic run_access(input logic st, input logic zx, input logic [1:0] sz,
                            input logic [31:0] addr, input logic [31:0] rt, input logic [31:0] rd,
                            input int a, input int d, input string nm, output logic [31:0] got);
    logic [31:0] exp_w, exp_ld, pc;
    logic [4:0]  dst;
    pc  = $urandom;
    dst = 5'($urandom_range(1, 31));
    ex_pc_i = pc; ex_alu_res_i = $urandom; ex_ls_addr_i = addr; ex_ls_ena_i = 1'b1;
    ex_ls_sel_i = {st, zx, sz}; ex_wb_reg_sel_i = ~st; ex_rt_data_i = rt;
    ex_w_reg_ena_i = ~st; ex_w_reg_dst_i = dst; ex_has_exception_i = 1'b0;
    exp_w  = model_store(sz, rt);
    exp_ld = model_load(sz, zx, addr[1:0], rd);
    got    = 32'd0;
    for (int c = 0; c < a + 1 + d; c++) begin
      bus.data_addr_ok = (c == a);
      bus.data_data_ok = (c == a + d);
      bus.data_rdata   = (c == a + d) ? rd : $urandom;
      #1;
      total++;
      if (bus.data_req !== 1'(c <= a)) begin
        bad++; $display("FAIL %s req c=%0d got=%b exp=%b", nm, c, bus.data_req, c <= a);
      end
      total++;
      if (mem_stall_o !== 1'(c < a + d)) begin
        bad++; $display("FAIL %s stall c=%0d got=%b exp=%b", nm, c, mem_stall_o, c < a + d);
      end
      if (c == 0) begin
        total++;
        if (mem_pc_o !== pc || mem_w_reg_ena_o !== ~st || mem_w_reg_dst_o !== dst) begin
          bad++; $display("FAIL %s passthru pc=%h ena=%b dst=%0d exp pc=%h ena=%b dst=%0d",
                          nm, mem_pc_o, mem_w_reg_ena_o, mem_w_reg_dst_o, pc, ~st, dst);
        end
      end
      if (c <= a) begin
        total++;
        if (bus.data_wr !== st || bus.data_size !== sz || bus.data_addr !== addr) begin
          bad++; $display("FAIL %s busfields wr=%b size=%0d addr=%h exp wr=%b size=%0d addr=%h",
                          nm, bus.data_wr, bus.data_size, bus.data_addr, st, sz, addr);
        end
        if (st) begin
          total++;
          if (bus.data_wdata !== exp_w) begin
            bad++; $display("FAIL %s wdata got=%h exp=%h", nm, bus.data_wdata, exp_w);
          end
        end
      end
      if (c == a + d) begin
        got = mem_w_reg_data_o;
        if (!st) begin
          total++;
          if (mem_w_reg_data_o !== exp_ld) begin
            bad++; $display("FAIL %s ldata got=%h exp=%h", nm, mem_w_reg_data_o, exp_ld);
          end
        end
      end
      step();
    end
    ex_ls_ena_i = 1'b0; ex_w_reg_ena_i = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_i = 1'b0; exception_flush = 1'b0;
    ex_pc_i = 32'h0; ex_alu_res_i = 32'h0; ex_ls_addr_i = 32'h40; ex_rt_data_i = 32'h0;
    ex_ls_ena_i = 1'b1; ex_ls_sel_i = 4'b0010; ex_wb_reg_sel_i = 1'b1;
    ex_w_reg_ena_i = 1'b1; ex_w_reg_dst_i = 5'd3; ex_has_exception_i = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    step(); step();
    total++;
    if (bus.data_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", bus.data_req); end
`ifdef MEM_STALL_CNT_EN
    total++;
    if (mem_stall_cnt_o !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", mem_stall_cnt_o); end
`endif
    ex_ls_ena_i = 1'b0; rst = 1'b0;
    #1;
    total++;
    if (bus.data_req !== 1'b0 || mem_stall_o !== 1'b0) begin
      bad++; $display("FAIL reset_idle req=%b stall=%b exp 0/0", bus.data_req, mem_stall_o);
    end
    step();
  endtask

  task automatic test_directed();
    logic [31:0] got;
    run_access(1'b0, 1'b0, 2'd2, 32'h100, 32'h0, 32'h89AB_CDEF, 0, 2, "ld_word", got);
    total++; if (got !== 32'h89AB_CDEF) begin bad++; $display("FAIL ld_word_k got=%h exp=89abcdef", got); end
    run_access(1'b0, 1'b0, 2'd0, 32'h103, 32'h0, 32'h80FF_0000, 0, 1, "ld_sbyte", got);
    total++; if (got !== 32'hFFFF_FF80) begin bad++; $display("FAIL ld_sbyte_k got=%h exp=ffffff80", got); end
    run_access(1'b0, 1'b1, 2'd0, 32'h103, 32'h0, 32'h80FF_0000, 1, 1, "ld_ubyte", got);
    total++; if (got !== 32'h0000_0080) begin bad++; $display("FAIL ld_ubyte_k got=%h exp=00000080", got); end
    run_access(1'b0, 1'b0, 2'd1, 32'h102, 32'h0, 32'h80FF_0000, 0, 3, "ld_shalf", got);
    total++; if (got !== 32'hFFFF_80FF) begin bad++; $display("FAIL ld_shalf_k got=%h exp=ffff80ff", got); end
    run_access(1'b1, 1'b0, 2'd0, 32'h101, 32'h1234_5678, 32'h0, 3, 1, "st_byte", got);
  endtask

  task automatic test_stall_done();
    logic [31:0] got;
    ex_ls_ena_i = 1'b1; ex_ls_sel_i = 4'b0010; ex_ls_addr_i = 32'h300; ex_wb_reg_sel_i = 1'b1;
    ex_w_reg_ena_i = 1'b1; ex_has_exception_i = 1'b0;
    bus.data_addr_ok = 1'b1;
    #1; step();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hCAFE_F00D; stall_i = 1'b1;
    #1;
    total++;
    if (mem_stall_o !== 1'b0 || mem_w_reg_data_o !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL stall_dok stall=%b data=%h exp 0/cafef00d", mem_stall_o, mem_w_reg_data_o);
    end
    step();
    for (int c = 0; c < 3; c++) begin
      bus.data_data_ok = 1'b0; bus.data_rdata = $urandom; stall_i = (c < 2);
      #1;
      total++;
      if (bus.data_req !== 1'b0 || mem_stall_o !== 1'b0 || mem_w_reg_data_o !== 32'hCAFE_F00D) begin
        bad++; $display("FAIL done_hold c=%0d req=%b stall=%b data=%h exp 0/0/cafef00d",
                        c, bus.data_req, mem_stall_o, mem_w_reg_data_o);
      end
      step();
    end
    stall_i = 1'b0; ex_ls_ena_i = 1'b0;
    run_access(1'b0, 1'b0, 2'd2, 32'h304, 32'h0, 32'h1357_9BDF, 0, 1, "after_done", got);
  endtask

  task automatic test_flush();
    logic [31:0] got;
    // Flush while waiting for read data: drain, then a fresh load issues.
    ex_ls_ena_i = 1'b1; ex_ls_sel_i = 4'b0010; ex_ls_addr_i = 32'h400; ex_wb_reg_sel_i = 1'b1;
    bus.data_addr_ok = 1'b1;
    #1; step();
    bus.data_addr_ok = 1'b0; exception_flush = 1'b1;
    #1;
    total++;
    if (bus.data_req !== 1'b0 || mem_stall_o !== 1'b1) begin
      bad++; $display("FAIL flush_wait req=%b stall=%b exp 0/1", bus.data_req, mem_stall_o);
    end
    step();
    exception_flush = 1'b0;
    for (int c = 0; c < 2; c++) begin
      bus.data_data_ok = (c == 1);
      #1;
      total++;
      if (bus.data_req !== 1'b0 || mem_stall_o !== 1'b1) begin
        bad++; $display("FAIL drain c=%0d req=%b stall=%b exp 0/1", c, bus.data_req, mem_stall_o);
      end
      step();
    end
    bus.data_data_ok = 1'b0;
    run_access(1'b0, 1'b0, 2'd2, 32'h408, 32'h0, 32'h2468_ACE0, 1, 2, "after_drain", got);
    // Flush in REQ cancels the request.
    ex_ls_ena_i = 1'b1; ex_ls_sel_i = 4'b0010; ex_wb_reg_sel_i = 1'b1;
    #1; step();
    exception_flush = 1'b1;
    #1;
    total++;
    if (bus.data_req !== 1'b0) begin bad++; $display("FAIL flush_req req=%b exp 0", bus.data_req); end
    step();
    exception_flush = 1'b0; ex_ls_ena_i = 1'b0;
    #1;
    total++;
    if (mem_stall_o !== 1'b0) begin bad++; $display("FAIL flush_req_idle stall=%b exp 0", mem_stall_o); end
    // Flush together with data_ok returns straight to IDLE.
    run_access(1'b0, 1'b0, 2'd2, 32'h40C, 32'h0, 32'h1111_2222, 0, 1, "pre_flushok", got);
    ex_ls_ena_i = 1'b1; ex_ls_sel_i = 4'b0010; ex_wb_reg_sel_i = 1'b1;
    bus.data_addr_ok = 1'b1;
    #1; step();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; exception_flush = 1'b1;
    #1; step();
    bus.data_data_ok = 1'b0; exception_flush = 1'b0; ex_ls_ena_i = 1'b0;
    #1;
    total++;
    if (mem_stall_o !== 1'b0) begin bad++; $display("FAIL flush_dok stall=%b exp 0", mem_stall_o); end
    step();
  endtask

  task automatic test_exception();
    ex_ls_ena_i = 1'b1; ex_has_exception_i = 1'b1; ex_w_reg_ena_i = 1'b1;
    ex_wb_reg_sel_i = 1'b0; ex_alu_res_i = 32'h5A5A_0F0F;
    #1;
    total++;
    if (bus.data_req !== 1'b0 || mem_stall_o !== 1'b0 || mem_w_reg_ena_o !== 1'b0) begin
      bad++; $display("FAIL has_exc req=%b stall=%b ena=%b exp 0/0/0", bus.data_req, mem_stall_o, mem_w_reg_ena_o);
    end
    total++;
    if (mem_w_reg_data_o !== 32'h5A5A_0F0F) begin
      bad++; $display("FAIL has_exc_alu got=%h exp=5a5a0f0f", mem_w_reg_data_o);
    end
    step();
    ex_ls_ena_i = 1'b0; ex_has_exception_i = 1'b0; ex_w_reg_ena_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    ex_ls_ena_i = 1'b1; ex_ls_sel_i = 4'b0010; ex_ls_addr_i = 32'h500; ex_wb_reg_sel_i = 1'b1;
    bus.data_addr_ok = 1'b1;
    #1; step();
    bus.data_addr_ok = 1'b0; rst = 1'b1;
    #1;
    total++;
    if (bus.data_req !== 1'b0) begin bad++; $display("FAIL rst_mid_req req=%b exp 0", bus.data_req); end
    step();
    rst = 1'b0;
    run_access(1'b0, 1'b1, 2'd1, 32'h502, 32'h0, 32'hBEEF_1234, 0, 1, "after_rst", got);
  endtask

  task automatic test_random();
    logic [31:0] got, addr, alu;
    logic [1:0]  sz;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        alu = $urandom;
        ex_ls_ena_i = 1'b0; ex_wb_reg_sel_i = 1'b0; ex_alu_res_i = alu; ex_w_reg_ena_i = 1'b1;
        #1;
        total++;
        if (mem_w_reg_data_o !== alu || mem_stall_o !== 1'b0 || bus.data_req !== 1'b0) begin
          bad++; $display("FAIL rnd_alu data=%h stall=%b req=%b exp %h/0/0", mem_w_reg_data_o, mem_stall_o, bus.data_req, alu);
        end
        step();
        ex_w_reg_ena_i = 1'b0;
      end else begin
        sz   = 2'($urandom_range(0, 2));
        addr = $urandom;
        if (sz == 2'd1) addr[0] = 1'b0;
        if (sz == 2'd2) addr[1:0] = 2'b00;
        run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, addr, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(1, 3), "rnd", got);
      end
    end
`ifdef MEM_STALL_CNT_EN
    #1;
    total++;
    if (mem_stall_cnt_o !== exp_cnt) begin bad++; $display("FAIL stall_cnt got=%0d exp=%0d", mem_stall_cnt_o, exp_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall_done();
    test_flush();
    test_exception();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
